// File: rtl/tug_of_war_referee_pkg.sv
// Shared types and constants for the tug-of-war referee.
package tug_pkg;

  // Referee game phases.
  typedef enum logic [1:0] {
    RECENTER = 2'd0,
    PLAY     = 2'd1,
    POINT    = 2'd2,
    DONE     = 2'd3
  } ref_state_t;

  localparam int DEFAULT_WIN_SCORE   = 7;
  localparam int DEFAULT_HOLD_CYCLES = 4;
  localparam int SCORE_W             = 3;

endpackage

// File: rtl/tug_of_war_referee_if.sv
// Signal bundle between the board keys / light row and the referee.
// The slave side is the referee, the master side is the board.
interface tug_of_war_referee_if;
  import tug_pkg::*;

  logic               l_key;
  logic               r_key;
  logic               row_left_on;
  logic               row_right_on;
  logic               l_press;
  logic               r_press;
  logic               row_reset;
  logic [SCORE_W-1:0] l_score;
  logic [SCORE_W-1:0] r_score;
  logic               match_over;
  logic               winner;

  modport master (
    output l_key, r_key, row_left_on, row_right_on,
    input  l_press, r_press, row_reset, l_score, r_score, match_over, winner
  );

  modport slave (
    input  l_key, r_key, row_left_on, row_right_on,
    output l_press, r_press, row_reset, l_score, r_score, match_over, winner
  );

endinterface

// File: rtl/tug_of_war_referee_key_conditioner.sv
// Raw key conditioning: two-flop synchroniser, rising-edge detect against a
// third flop, and a registered edge flag so downstream decode is flop-only.
module key_conditioner (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic edge_q;

  // Synchronise the key, remember the last level and register the rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= sync2_q & ~prev_q;
    end
  end

  assign pulse = edge_q;

endmodule

// File: rtl/tug_of_war_referee.sv
// Tug-of-war referee: conditions both keys, forwards single presses to the
// light row, scores points at the end lights and sequences the rounds.
module tug_of_war_referee
  import tug_pkg::*;
#(
  parameter int WIN_SCORE   = DEFAULT_WIN_SCORE,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input logic                 clk,
  input logic                 reset,
  tug_of_war_referee_if.slave bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  logic lEdge;
  logic rEdge;

  ref_state_t         state_q,   state_d;
  logic [SCORE_W-1:0] lScore_q,  lScore_d;
  logic [SCORE_W-1:0] rScore_q,  rScore_d;
  logic [HOLD_W-1:0]  holdCnt_q, holdCnt_d;
  logic               winner_q,  winner_d;

  logic lPress;
  logic rPress;
  logic rowReset;
  logic matchOver;

  key_conditioner uLeftKey (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.l_key),
    .pulse (lEdge)
  );

  key_conditioner uRightKey (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.r_key),
    .pulse (rEdge)
  );

  // State, score, hold-counter and winner registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RECENTER;
      lScore_q  <= '0;
      rScore_q  <= '0;
      holdCnt_q <= '0;
      winner_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lScore_q  <= lScore_d;
      rScore_q  <= rScore_d;
      holdCnt_q <= holdCnt_d;
      winner_q  <= winner_d;
    end
  end

  // Round sequencing, press gating and scoring; a simultaneous left/right
  // edge is dropped entirely so neither player gains from mashing both.
  always_comb begin
    state_d   = state_q;
    lScore_d  = lScore_q;
    rScore_d  = rScore_q;
    holdCnt_d = holdCnt_q;
    winner_d  = winner_q;
    lPress    = 1'b0;
    rPress    = 1'b0;
    rowReset  = 1'b0;
    matchOver = 1'b0;

    case (state_q)
      RECENTER: begin
        rowReset = 1'b1;
        state_d  = PLAY;
      end

      PLAY: begin
        lPress = lEdge & ~rEdge;
        rPress = rEdge & ~lEdge;
        if (lPress && bus.row_left_on && (lScore_q != WIN_VAL)) begin
          lScore_d = lScore_q + SCORE_W'(1);
          if (lScore_d == WIN_VAL) begin
            state_d  = DONE;
            winner_d = 1'b0;
          end else begin
            state_d   = POINT;
            holdCnt_d = HOLD_LOAD;
          end
        end else if (rPress && bus.row_right_on && (rScore_q != WIN_VAL)) begin
          rScore_d = rScore_q + SCORE_W'(1);
          if (rScore_d == WIN_VAL) begin
            state_d  = DONE;
            winner_d = 1'b1;
          end else begin
            state_d   = POINT;
            holdCnt_d = HOLD_LOAD;
          end
        end
      end

      POINT: begin
        if (holdCnt_q == '0) begin
          state_d = RECENTER;
        end else begin
          holdCnt_d = holdCnt_q - HOLD_W'(1);
        end
      end

      DONE: begin
        matchOver = 1'b1;
      end

      default: begin
        state_d = RECENTER;
      end
    endcase
  end

  assign bus.l_press    = lPress;
  assign bus.r_press    = rPress;
  assign bus.row_reset  = rowReset;
  assign bus.l_score    = lScore_q;
  assign bus.r_score    = rScore_q;
  assign bus.match_over = matchOver;
  assign bus.winner     = winner_q;

endmodule
